// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low hex glyphs, blank code and
// the editor operation decode used by the multi-digit editor.
package seg_pkg;

    // Active-low segments, bit0 = a ... bit6 = g; entry k is the glyph for hex digit k.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Button vector bit positions: {clr, right, left, inc, dec}.
    localparam int BTN_CLR   = 4;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_INC   = 1;
    localparam int BTN_DEC   = 0;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLR,
        EV_RIGHT,
        EV_LEFT,
        EV_INC,
        EV_DEC
    } edit_op_t;

    // Only the highest-priority event of a cycle is acted on.
    function automatic edit_op_t pick_op(input logic [4:0] evt);
        if (evt[BTN_CLR])        return EV_CLR;
        else if (evt[BTN_RIGHT]) return EV_RIGHT;
        else if (evt[BTN_LEFT])  return EV_LEFT;
        else if (evt[BTN_INC])   return EV_INC;
        else if (evt[BTN_DEC])   return EV_DEC;
        else                     return EV_NONE;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment glyph.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_GLYPH[digit];

endmodule

// File: rtl/multi_digit_editor.sv
// Multi-digit seven-segment editor: button edge detect, cursor/value edit,
// digit scan with registered segment decode, and cursor blink.
module multi_digit_editor
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BASE      = 10,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_right,
    input  logic                  btn_left,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic                  btn_clr,
    output logic [DIGITS-1:0]     sel_n,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     cursor,
    output logic [4*DIGITS-1:0]   value
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [3:0]         MAX_DIGIT  = 4'(BASE - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [4:0]            btn_vec;
    logic [4:0]            btn_prev_reg;
    logic [4:0]            btn_evt_reg;
    edit_op_t              op;

    logic [DIGITS-1:0]     cursor_reg, cursor_next;
    logic [4*DIGITS-1:0]   value_reg, value_next;
    logic [3:0]            digit_inc [DIGITS];
    logic [3:0]            digit_dec [DIGITS];

    logic [SCAN_W-1:0]     scan_cnt_reg, scan_cnt_next;
    logic [IDX_W-1:0]      scan_idx_reg, scan_idx_next;
    logic [BLINK_W-1:0]    blink_cnt_reg, blink_cnt_next;
    logic                  phase_reg, phase_next;

    logic [DIGITS-1:0]     sel_n_reg, sel_n_next;
    logic [6:0]            seg_n_reg, seg_n_next;
    logic [3:0]            scan_digit;
    logic [6:0]            glyph;

    assign btn_vec = {btn_clr, btn_right, btn_left, btn_inc, btn_dec};
    assign op      = pick_op(btn_evt_reg);

    // Register previous levels and the rising-edge events. During reset the
    // previous level tracks the live input so a button held through reset
    // release is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_reg <= btn_vec;
            btn_evt_reg  <= '0;
        end else begin
            btn_prev_reg <= btn_vec;
            btn_evt_reg  <= btn_vec & ~btn_prev_reg;
        end
    end

    // Per-digit modular increment and decrement candidates.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            assign d             = value_reg[4*gi +: 4];
            assign digit_inc[gi] = (d == MAX_DIGIT) ? 4'd0 : d + 4'd1;
            assign digit_dec[gi] = (d == 4'd0) ? MAX_DIGIT : d - 4'd1;
        end
    endgenerate

    // Apply the selected edit to the cursor and digit values.
    always_comb begin
        cursor_next = cursor_reg;
        value_next  = value_reg;
        case (op)
            EV_CLR: begin
                value_next  = '0;
                cursor_next = DIGITS'(1);
            end
            EV_RIGHT: cursor_next = {cursor_reg[0], cursor_reg[DIGITS-1:1]};
            EV_LEFT:  cursor_next = {cursor_reg[DIGITS-2:0], cursor_reg[DIGITS-1]};
            EV_INC: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (cursor_reg[k]) value_next[4*k +: 4] = digit_inc[k];
                end
            end
            EV_DEC: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (cursor_reg[k]) value_next[4*k +: 4] = digit_dec[k];
                end
            end
            default: ;
        endcase
    end

    // Free-running scan slot counter and blink phase; any edit restarts blink visible.
    always_comb begin
        scan_cnt_next  = scan_cnt_reg + SCAN_W'(1);
        scan_idx_next  = scan_idx_reg;
        blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
        phase_next     = phase_reg;
        if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_next = '0;
            scan_idx_next = (scan_idx_reg == LAST_IDX) ? '0 : scan_idx_reg + IDX_W'(1);
        end
        if (op != EV_NONE) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end
    end

    // Decode the digit that will be scanned next cycle so seg_n lines up with sel_n.
    assign scan_digit = value_next[{scan_idx_next, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .digit (scan_digit),
        .seg_n (glyph)
    );

    // Next display outputs: one active-low select, glyph or blank for the cursor digit.
    always_comb begin
        sel_n_next = ~(DIGITS'(1) << scan_idx_next);
        seg_n_next = glyph;
        if (phase_next && cursor_next[scan_idx_next]) seg_n_next = SEG_BLANK;
    end

    // Editor, scan, blink and display state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_reg    <= DIGITS'(1);
            value_reg     <= '0;
            scan_cnt_reg  <= '0;
            scan_idx_reg  <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            sel_n_reg     <= ~DIGITS'(1);
            seg_n_reg     <= HEX_GLYPH[0];
        end else begin
            cursor_reg    <= cursor_next;
            value_reg     <= value_next;
            scan_cnt_reg  <= scan_cnt_next;
            scan_idx_reg  <= scan_idx_next;
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            sel_n_reg     <= sel_n_next;
            seg_n_reg     <= seg_n_next;
        end
    end

    assign cursor = cursor_reg;
    assign value  = value_reg;
    assign sel_n  = sel_n_reg;
    assign seg_n  = seg_n_reg;

endmodule
